dcm_prog_responder: RTL
=======================

Name: dcm_prog_responder

Overview:
Synthesizable responder for the DCM_CLKGEN serial programming port, i.e. the receiving end of the dcm_prog_en / dcm_prog_data / dcm_prog_done interface that our clock controller drives.
- Decodes LoadD, LoadM and GO commands and holds pending and active D-1 / M-1 values.
- Models relock time and drives dcm_prog_done.
- Used as the DCM stand-in for controller simulation and board bring-up loopback. Also usable as a soft frequency-register target on parts without a real DCM.

Parameters:
INITIAL_M_S1, 8'd15, active M-1 after reset (multiplier 16).
INITIAL_D_S1, 8'd7, active D-1 after reset (divider 8).
DONE_LATENCY, 16, clk cycles from GO acceptance to dcm_prog_done reassertion (≥1).

Ports:
clk  input  1  programming clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
dcm_prog_en  input  1  PROGEN from controller.
dcm_prog_data  input  1  PROGDATA from controller; bits are LSB first.
dcm_prog_done  output  1  PROGDONE. High = locked/idle. Low during programming and relock.
active_m_s1  output  8  applied M-1.
active_d_s1  output  8  applied D-1.
active_mult  output  9  active_m_s1 + 1, zero-extended.
cfg_update  output  1  one-cycle pulse when a new config is applied.
prog_error  output  1  sticky protocol/range error flag.

Behaviour:
- Reset (async, any state):
  - state = IDLE; dcm_prog_done = 1.
  - active_m_s1 = INITIAL_M_S1, active_d_s1 = INITIAL_D_S1.
  - pending_m_s1 = INITIAL_M_S1, pending_d_s1 = INITIAL_D_S1.
  - cfg_update = 0, prog_error = 0; bit counter and shift register = 0.
- All outputs are registered.
- States: IDLE, SEL, SHIFT, TAIL, GO_CHK, LOCK, ERR.
- IDLE:
  - en=0: stay.
  - en=1, data=1: start of a load. Go to SEL; done <= 0 next cycle.
  - en=1, data=0: GO. Go to GO_CHK; done <= 0.
- SEL:
  - en=1, data=0: target = D. en=1, data=1: target = M. Either way go to SHIFT with count = 0.
  - en=0: go to ERR.
- SHIFT:
  - Requires en=1 for exactly 8 cycles. Each cycle: shift = {data, shift[7:1]}; count++.
  - After the 8th bit go to TAIL.
  - en=0 before 8 bits: go to ERR; the partial word is discarded.
- TAIL:
  - en=0: write shift into pending_d_s1 or pending_m_s1 per target; go to IDLE. done stays 0.
  - en=1 (word longer than 8 bits): go to ERR; pending is unchanged.
- GO_CHK:
  - en=1 (GO held longer than 1 cycle): go to ERR.
  - en=0 and pending_m_s1 == 0 (M=1 is illegal): go to ERR.
  - Otherwise: load the lock counter with DONE_LATENCY-1; go to LOCK.
- LOCK:
  - Count down. en is ignored (the real DCM ignores it while locking).
  - At count 0, in the same cycle:
    - active <= pending;
    - cfg_update pulses 1 cycle;
    - done <= 1;
    - go to IDLE.
- GO latency: from the GO cycle to done=1 is DONE_LATENCY+1 cycles.
- GO without any prior load is accepted; it relocks with the current pending values.
- ERR:
  - prog_error <= 1 (sticky until reset).
  - Pending values revert to the active values.
  - Wait for en=0, then go to IDLE. done stays 0 until the next successful GO.
- done=0 from the first load command until the GO completes, including across multiple loads.
- Reset during LOCK: config is not applied; outputs return to INITIAL_*.
- Arithmetic: active_mult = {1'b0, active_m_s1} + 9'd1. 255 → 256; no wrap.
- D has no range check; D-1 in 0..255 is legal.

Decomposition:
- Package dcm_prog_pkg holds:
  - state enum;
  - command encodings: CMD_START=1, SEL_D=0, SEL_M=1, GO_DATA=0;
  - PROG_WORD_W=8.
- One sub-module, dcm_prog_word_rx. It is the 8-bit LSB-first shift register plus 3-bit counter, with ports:
  - inputs shift_en, bit_in, clear;
  - outputs word[7:0], word_full.
- The FSM, pending/active registers and lock counter stay in the top module.

Test Plan:
1. Reset, then idle. Required: done=1, active_m_s1=15, active_d_s1=7, active_mult=16, prog_error=0.
2. Standard controller sequence. Stimulus:
   - en/data = 11,10, then 8 bits of D-1=7 (LSB first);
   - en=0 for 3 cycles;
   - 11,11, then 8 bits of M-1=31;
   - en=0 for 2 cycles;
   - GO (en/data=10), then en=0.
   Required:
   - done falls the cycle after the first en;
   - done rises exactly DONE_LATENCY+1 cycles after GO;
   - cfg_update pulses once;
   - active_mult=32; active_d_s1=7.
3. Load M-1=0x00, then GO. Required: prog_error=1; done stays 0; active_m_s1 stays 15.
4. Load M with only 5 bits, then en drops. Required: ERR; pending unchanged; a following valid load M-1=63 plus GO gives active_mult=64; prog_error remains 1.
5. Load M-1=255, then GO. Required: active_mult=9'd256. A second GO with no load: relocks, cfg_update pulses again, values unchanged.
6. Async reset asserted mid-LOCK after loading M-1=47. Required: immediately done=1, active_mult=16, no cfg_update pulse.

Source files
------------

// File: rtl/dcm_prog_pkg.sv
// Shared types and command encodings for the DCM_CLKGEN programming-port responder.
package dcm_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        TAIL,
        GO_CHK,
        LOCK,
        ERR
    } state_e;

    localparam logic CMD_START = 1'b1;
    localparam logic SEL_D     = 1'b0;
    localparam logic SEL_M     = 1'b1;
    localparam logic GO_DATA   = 1'b0;

    localparam int unsigned PROG_WORD_W = 8;

    function automatic logic [PROG_WORD_W:0] mult_of(input logic [PROG_WORD_W-1:0] m_s1);
        return {1'b0, m_s1} + {{PROG_WORD_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dcm_prog_word_rx.sv
// LSB-first serial word receiver: shift register plus bit counter.
module dcm_prog_word_rx
    import dcm_prog_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic                   bit_in,
    input  logic                   clear,
    output logic [PROG_WORD_W-1:0] word,
    output logic                   word_full
);

    localparam int unsigned CNT_W = $clog2(PROG_WORD_W);

    logic [PROG_WORD_W-1:0] word_q;
    logic [CNT_W-1:0]       cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= {bit_in, word_q[PROG_WORD_W-1:1]};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign word = word_q;
    // High while the final bit of the word is being shifted in.
    assign word_full = shift_en && (cnt_q == CNT_W'(PROG_WORD_W - 1));

endmodule

// File: rtl/dcm_prog_responder.sv
// DCM_CLKGEN programming-port responder: decodes LoadD/LoadM/GO, holds pending and
// active D-1/M-1, and models relock time on dcm_prog_done.
module dcm_prog_responder
    import dcm_prog_pkg::*;
#(
    parameter logic [7:0]  INITIAL_M_S1 = 8'd15,
    parameter logic [7:0]  INITIAL_D_S1 = 8'd7,
    parameter int unsigned DONE_LATENCY = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dcm_prog_en,
    input  logic       dcm_prog_data,
    output logic       dcm_prog_done,
    output logic [7:0] active_m_s1,
    output logic [7:0] active_d_s1,
    output logic [8:0] active_mult,
    output logic       cfg_update,
    output logic       prog_error
);

    localparam int unsigned LOCK_W = (DONE_LATENCY > 1) ? $clog2(DONE_LATENCY) : 1;

    state_e      state_q;
    logic        tgt_m_q;
    logic [7:0]  pend_m_q, pend_d_q;
    logic [7:0]  act_m_q, act_d_q;
    logic [8:0]  mult_q;
    logic [LOCK_W-1:0] lock_q;
    logic        done_q, cfg_q, err_q;

    logic        rx_shift_en, rx_clear, rx_full;
    logic [PROG_WORD_W-1:0] rx_word;

    assign rx_shift_en = (state_q == SHIFT) && dcm_prog_en;
    assign rx_clear    = (state_q != SHIFT);

    dcm_prog_word_rx u_word_rx (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (rx_shift_en),
        .bit_in    (dcm_prog_data),
        .clear     (rx_clear),
        .word      (rx_word),
        .word_full (rx_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tgt_m_q  <= 1'b0;
            pend_m_q <= INITIAL_M_S1;
            pend_d_q <= INITIAL_D_S1;
            act_m_q  <= INITIAL_M_S1;
            act_d_q  <= INITIAL_D_S1;
            mult_q   <= mult_of(INITIAL_M_S1);
            lock_q   <= '0;
            done_q   <= 1'b1;
            cfg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cfg_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dcm_prog_en) begin
                        done_q <= 1'b0;
                        case (dcm_prog_data)
                            CMD_START: state_q <= SEL;
                            GO_DATA:   state_q <= GO_CHK;
                        endcase
                    end
                end
                SEL: begin
                    if (dcm_prog_en) begin
                        case (dcm_prog_data)
                            SEL_M: tgt_m_q <= 1'b1;
                            SEL_D: tgt_m_q <= 1'b0;
                        endcase
                        state_q <= SHIFT;
                    end else begin
                        state_q <= ERR;
                    end
                end
                SHIFT: begin
                    if (!dcm_prog_en) state_q <= ERR;
                    else if (rx_full) state_q <= TAIL;
                end
                TAIL: begin
                    if (dcm_prog_en) begin
                        state_q <= ERR;
                    end else begin
                        if (tgt_m_q) pend_m_q <= rx_word;
                        else         pend_d_q <= rx_word;
                        state_q <= IDLE;
                    end
                end
                GO_CHK: begin
                    // M-1 of zero (multiplier 1) is not a legal DCM setting.
                    if (dcm_prog_en || (pend_m_q == '0)) begin
                        state_q <= ERR;
                    end else begin
                        lock_q  <= LOCK_W'(DONE_LATENCY - 1);
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (lock_q == '0) begin
                        act_m_q <= pend_m_q;
                        act_d_q <= pend_d_q;
                        mult_q  <= mult_of(pend_m_q);
                        cfg_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        lock_q <= lock_q - 1'b1;
                    end
                end
                ERR: begin
                    err_q    <= 1'b1;
                    pend_m_q <= act_m_q;
                    pend_d_q <= act_d_q;
                    if (!dcm_prog_en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dcm_prog_done = done_q;
    assign active_m_s1   = act_m_q;
    assign active_d_s1   = act_d_q;
    assign active_mult   = mult_q;
    assign cfg_update    = cfg_q;
    assign prog_error    = err_q;

endmodule
